// File: rtl/pt2262_pkg.sv
// Shared PT2262/PT2272 encoding constants: trit codes, segment widths, sync timing, FSM states.
package pt2262_pkg;

   localparam logic [1:0] TRIT_0   = 2'b00;
   localparam logic [1:0] TRIT_1   = 2'b11;
   localparam logic [1:0] TRIT_F   = 2'b10;
   localparam logic [1:0] TRIT_ILL = 2'b01;

   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] SYNC_HIGH = 7'd4;
   localparam logic [SEG_W-1:0] SYNC_LOW  = 7'd124;
   localparam int BIT_TICKS   = 32;
   localparam int FRAME_TICKS = 512;
   localparam int N_SYMBOLS   = 12;
   localparam logic [3:0] LAST_SYMBOL = 4'd11;

   // Segment widths in ticks, index 0 first; even segments high, odd low.
   localparam logic [3:0][SEG_W-1:0] SEG_TAB_0 = {7'd12, 7'd4, 7'd12, 7'd4};
   localparam logic [3:0][SEG_W-1:0] SEG_TAB_1 = {7'd4, 7'd12, 7'd4, 7'd12};
   localparam logic [3:0][SEG_W-1:0] SEG_TAB_F = {7'd4, 7'd12, 7'd12, 7'd4};

   typedef enum logic [1:0] {SYM_0, SYM_1, SYM_F} sym_t;
   typedef enum logic [1:0] {IDLE, SEND_BIT, SEND_SYNC, FRAME_END} state_t;

   function automatic sym_t trit_to_sym(logic [1:0] t);
      case (t)
         TRIT_0:   return SYM_0;
         TRIT_1:   return SYM_1;
         TRIT_F:   return SYM_F;
         TRIT_ILL: return SYM_F;
         default:  return SYM_F;
      endcase
   endfunction

   function automatic logic [SEG_W-1:0] seg_width(sym_t s, logic [1:0] seg);
      case (s)
         SYM_1:   return SEG_TAB_1[seg];
         SYM_F:   return SEG_TAB_F[seg];
         default: return SEG_TAB_0[seg];
      endcase
   endfunction

   // Symbols 0..7 are address trits (A[1:0] first), 8..11 are data bits D[0]..D[3].
   function automatic sym_t symbol_at(logic [15:0] a, logic [3:0] d, logic [3:0] idx);
      if (idx < 4'd8) return trit_to_sym(a[{idx[2:0], 1'b0} +: 2]);
      else            return d[idx[1:0]] ? SYM_1 : SYM_0;
   endfunction

endpackage

// File: rtl/pt2262_tick_gen.sv
// Oscillator prescaler: one-clk tick enable every DIVIDER clocks, first tick DIVIDER clocks after reset.
module pt2262_tick_gen #(
   parameter int DIVIDER = 250
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);

   localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/encodificador_pt2262.sv
// PT2262-style trinary encoder: 8 address trits + 4 data bits + sync per 512-tick frame.
// Define ENC_MIN_FRAMES_EN to guarantee at least MIN_FRAMES frames per transmission.
//
// state     | meaning
// IDLE      | line low, waiting for te on a tick
// SEND_BIT  | driving the 4 segments of symbols 0..11
// SEND_SYNC | sync high 4 ticks, then low for all but the last sync tick
// FRAME_END | last low sync tick; decides next frame or return to IDLE
module encodificador_pt2262
   import pt2262_pkg::*;
#(
   parameter int DIVIDER    = 250,
   parameter int MIN_FRAMES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] A,
   input  logic [3:0]  D,
   input  logic        te,
   output logic        cod_o,
   output logic        busy,
   output logic        frame_done
);

   logic tick;

   pt2262_tick_gen #(.DIVIDER(DIVIDER)) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .tick_o (tick)
   );

   state_t           state_q, state_d;
   logic [3:0]       sym_q, sym_d;
   logic [1:0]       seg_q, seg_d;
   logic [SEG_W-1:0] left_q, left_d;
   logic             cod_q, cod_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [15:0]      a_q, a_d;
   logic [3:0]       d_q, d_d;
   logic             start, cont;
   sym_t             cur_sym, nxt_sym;

`ifdef ENC_MIN_FRAMES_EN
   logic [2:0] frm_q, frm_d, frm_inc;
`else
   logic unused_min_frames;
   assign unused_min_frames = (MIN_FRAMES != 0);
`endif

   assign cur_sym = symbol_at(a_q, d_q, sym_q);
   assign nxt_sym = symbol_at(a_q, d_q, sym_q + 4'd1);

   always_comb begin
      state_d = state_q;
      sym_d   = sym_q;
      seg_d   = seg_q;
      left_d  = left_q;
      cod_d   = cod_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      a_d     = a_q;
      d_d     = d_q;
      start   = 1'b0;
`ifdef ENC_MIN_FRAMES_EN
      frm_d   = frm_q;
      frm_inc = (frm_q == 3'd7) ? 3'd7 : frm_q + 3'd1;
      cont    = te || (int'(frm_inc) < MIN_FRAMES);
`else
      cont    = te;
`endif
      if (tick) begin
         case (state_q)
            IDLE: start = te;
            SEND_BIT: begin
               if (left_q != '0) begin
                  left_d = left_q - 7'd1;
               end else if (seg_q != 2'd3) begin
                  seg_d  = seg_q + 2'd1;
                  cod_d  = ~cod_q;
                  left_d = seg_width(cur_sym, seg_q + 2'd1) - 7'd1;
               end else if (sym_q != LAST_SYMBOL) begin
                  sym_d  = sym_q + 4'd1;
                  seg_d  = 2'd0;
                  cod_d  = 1'b1;
                  left_d = seg_width(nxt_sym, 2'd0) - 7'd1;
               end else begin
                  state_d = SEND_SYNC;
                  seg_d   = 2'd0;
                  cod_d   = 1'b1;
                  left_d  = SYNC_HIGH - 7'd1;
               end
            end
            SEND_SYNC: begin
               if (left_q != '0) begin
                  left_d = left_q - 7'd1;
               end else if (seg_q == 2'd0) begin
                  seg_d  = 2'd1;
                  cod_d  = 1'b0;
                  // FRAME_END supplies the final low tick of the sync gap
                  left_d = SYNC_LOW - 7'd2;
               end else begin
                  state_d = FRAME_END;
               end
            end
            FRAME_END: begin
               done_d = 1'b1;
`ifdef ENC_MIN_FRAMES_EN
               frm_d  = frm_inc;
`endif
               if (cont) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  cod_d   = 1'b0;
`ifdef ENC_MIN_FRAMES_EN
                  frm_d   = 3'd0;
`endif
               end
            end
            default: state_d = IDLE;
         endcase
         if (start) begin
            a_d     = A;
            d_d     = D;
            state_d = SEND_BIT;
            sym_d   = 4'd0;
            seg_d   = 2'd0;
            cod_d   = 1'b1;
            busy_d  = 1'b1;
            left_d  = seg_width(symbol_at(A, D, 4'd0), 2'd0) - 7'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sym_q   <= '0;
         seg_q   <= '0;
         left_q  <= '0;
         cod_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= '0;
         d_q     <= '0;
`ifdef ENC_MIN_FRAMES_EN
         frm_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sym_q   <= sym_d;
         seg_q   <= seg_d;
         left_q  <= left_d;
         cod_q   <= cod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         a_q     <= a_d;
         d_q     <= d_d;
`ifdef ENC_MIN_FRAMES_EN
         frm_q   <= frm_d;
`endif
      end
   end

   assign cod_o      = cod_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: doc/encodificador_pt2262.md
ENCODIFICADOR_PT2262 -- requirements
Module: encodificador_pt2262

Interface
REQ-001 Parameter DIVIDER, default 250, meaning clk cycles per oscillator tick (3 MHz / 250 = 12 kHz).
REQ-002 Parameter MIN_FRAMES, default 4, meaning minimum frames per transmission when ENC_MIN_FRAMES_EN is defined.
REQ-003 Port clk, input, 1, meaning single 3 MHz clock; every flop is on posedge clk.
REQ-004 Port reset, input, 1, meaning reset: synchronous, active-high.
REQ-005 Port A, input, 16, meaning 8 trinary address trits; trit k = A[2k+1:2k]; 00 = 0, 11 = 1, 10 = F, 01 = illegal.
REQ-006 Port D, input, 4, meaning data bits to transmit.
REQ-007 Port te, input, 1, meaning transmit enable, active high, level-sensitive.
REQ-008 Port cod_o, output, 1, meaning registered encoded serial stream (feeds decoder cod_i).
REQ-009 Port busy, output, 1, meaning high while a frame is in progress.
REQ-010 Port frame_done, output, 1, meaning 1-clk pulse when a frame's sync bit completes.

Function
REQ-011 Internal prescaler counts 0..DIVIDER-1 and asserts tick for one clk when at DIVIDER-1; tick is an enable, not a derived clock.
REQ-012 cod_o, busy and frame_done change only on clk edges where tick = 1, except reset.
REQ-013 Bit waveforms in ticks (H = cod_o high, L = low): bit 0 = H4 L12 H4 L12; bit 1 = H12 L4 H12 L4; bit F = H4 L12 H12 L4; sync = H4 L124.
REQ-014 Frame order: trit 0 .. trit 7 (A[1:0] first), then D[0] .. D[3], then sync; frame length 512 ticks.
REQ-015 An illegal address trit (01) is transmitted as F.
REQ-016 A and D are captured into a frame register at each frame start and held constant for the frame; changes mid-frame affect only the next frame.
REQ-017 FSM states: IDLE, SEND_BIT (12 symbols, 4 segments each), SEND_SYNC, FRAME_END.
REQ-018 IDLE: cod_o = 0, busy = 0; on a tick with te = 1, capture A/D, enter SEND_BIT, cod_o = 1 and busy = 1 on that same tick.
REQ-019 SEND_BIT: segment counter counts ticks per REQ-013; after symbol 11's last segment, enter SEND_SYNC.
REQ-020 SEND_SYNC: after 128 ticks, enter FRAME_END, pulse frame_done for one clk, increment 3-bit saturating frame counter.
REQ-021 FRAME_END: if continue condition (REQ-027/028) holds, start next frame on the very next tick with no gap; else return to IDLE, busy = 0, frame counter cleared.
REQ-022 te falling mid-frame never truncates a frame; the current frame always completes.
REQ-023 te rising during FRAME_END of a stopping transmission is sampled on the next IDLE tick (one tick of low gap).

Reset
REQ-024 reset = 1 at any clk edge, including mid-frame: next state IDLE, prescaler = 0, counters = 0, cod_o = 0, busy = 0, frame_done = 0.
REQ-025 After reset deassertion, first tick occurs DIVIDER clk cycles later.

Configuration
REQ-026 Macro ENC_MIN_FRAMES_EN selects the minimum-frame feature.
REQ-027 Defined: continue condition = te = 1 or frames sent < MIN_FRAMES; a te pulse of any width yields at least MIN_FRAMES frames.
REQ-028 Not defined: continue condition = te = 1 only; MIN_FRAMES is ignored and the frame counter is not built.

Structure
REQ-029 Package pt2262_pkg holds the trit encoding constants (00/11/10/01), the segment width table of REQ-013, the sync widths (4/124), the bit and frame lengths (32/512) and the FSM state enum; the decoder shares the same encoding constants.
REQ-030 One sub-module, pt2262_tick_gen, holds the DIVIDER prescaler; all waveform logic stays in the top.

Verification
REQ-031 DIVIDER = 2, A = all 00, D = 4'b0000, te high for one frame: 12 symbols of H4 L12 H4 L12, then H4 L124; frame_done pulses once at tick 512.
REQ-032 A = 16'b11_10_00_01_11_00_10_11, D = 4'b1010: trits in order 1, F, 0, 1, F, 0, F, 1 (illegal 01 sent as F, A[1:0] first), then data symbols D[0]..D[3] = 0, 1, 0, 1.
REQ-033 te held high across 3 frames: frames are back-to-back, busy stays high, frame_done pulses 3 times; D changed mid-frame appears only in the next frame.
REQ-034 ENC_MIN_FRAMES_EN defined, te high for 1 tick: exactly 4 frames, then IDLE. Undefined: exactly 1 frame.
REQ-035 reset asserted at tick 200 of a frame: cod_o = 0 and busy = 0 on the next clk; a later te starts a clean frame from trit 0.
REQ-036 Loopback into decodificador_pt2272 with matching address: decoded D equals the transmitted D, and dv asserts.
